multiplier: RTL and testbench
=============================

Name: multiplier

Overview:
- Iterative 32-bit integer multiplier for the ALU of the pipelined processor.
- Takes two operands on a one-cycle Start pulse and computes signed or unsigned A*B with a radix-2 shift-add datapath.
- Returns the low 32 bits of the product on R and raises Ready.
- The pipeline stalls on Ready.

Parameters:
- WIDTH, 32, operand/result width. All counts below assume 32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- Start  in  1  begin operation; sampled on rising clk
- Signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with Start
- A  in  [0:WIDTH-1]  multiplicand; bit 0 is MSB (codebase big-endian bit numbering)
- B  in  [0:WIDTH-1]  multiplier; bit 0 is MSB
- R  out  [0:WIDTH-1]  low WIDTH bits of the product; bit 0 is MSB; registered
- Ready  out  1  result valid; registered

Behaviour:
- Reset (rst_n=0 at rising clk):
  - state=IDLE, R=0, Ready=0, internal registers cleared.
  - Has priority over everything, including mid-operation; the operation in progress is discarded.
- States: IDLE, BUSY, DONE.
- Start sampled high in any state (IDLE, DONE or BUSY):
  - Latch A, B, Signed.
  - Ready<=0; R holds its previous value.
  - Counter<=WIDTH; go to BUSY.
  - Start while BUSY aborts and restarts with the new operands. Start only needs to be high for one edge; holding it high restarts every cycle.
- Operand conditioning at capture:
  - Signed=1: magnitudes |A|, |B|; neg = A[0] XOR B[0].
  - Signed=0: operands used as-is; neg=0.
  - |-2^31| is 0x80000000 treated as unsigned; the result is still correct mod 2^32.
- BUSY, each edge:
  - If multiplier LSB = 1, add multiplicand to the 32-bit accumulator.
  - Shift multiplicand left by 1, multiplier right by 1; decrement counter.
  - After the WIDTH-th iteration go to DONE.
  - Only the low 32 bits are kept; overflow beyond 32 bits is silently discarded with no flag.
- Entering DONE (same edge as the last iteration):
  - R <= neg ? two's-complement negation of accumulator : accumulator.
  - Ready<=1.
- Latency: Start sampled at edge N; R valid and Ready=1 after edge N+WIDTH (32 cycles). Ready is low for edges N..N+31.
- DONE: R and Ready hold indefinitely until the next Start or reset. Operand changes without Start do not affect R.
- IDLE (after reset only): Ready=0 until the first completed operation.
- Signed and unsigned results are identical mod 2^32 for the same bit patterns; the Signed path exists so the datapath can be extended to a high-word result.
- Zero operands: full latency, R=0. No early termination.

Decomposition:
- Shared package mult_pkg:
  - WIDTH constant.
  - state enum {IDLE, BUSY, DONE}.
  - counter width = clog2(WIDTH)+1.
- Single module multiplier; no sub-module required.
- The magnitude/negate logic may be a function in mult_pkg.

Test Plan:
- Unsigned: Signed=0, A=3, B=5, Start pulse -> Ready low for 32 cycles, then R=15 (0x0000000F), Ready=1 held.
- Back-to-back: after Ready, Start with A=7, B=9 -> Ready drops on the start edge, then R=63 after 32 cycles.
- Signed negative operand: Signed=1, A=-4, B=8 -> R=0xFFFFFFE0 (-32). Signed=1, A=5, B=-2 -> R=0xFFFFFFF6 (-10).
- Signed both negative: A=-15, B=-12 -> R=180. Unsigned A=0xFFFFFFFF, B=2 -> R=0xFFFFFFFE (truncation).
- Restart/hold: Start reasserted mid-BUSY with A=6, B=7 -> R=42 exactly 32 cycles after the second Start. Operand change in DONE without Start -> R unchanged.
- Reset: rst_n=0 mid-BUSY -> next edge Ready=0, R=0, state IDLE. No Ready until a new Start completes.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and types for the iterative shift-add multiplier.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplier_if.sv
// Operand/result bundle between the pipeline and the multiplier; bit 0 of each vector is the MSB.
interface multiplier_if #(
    parameter int WIDTH = mult_pkg::WIDTH
);
    logic             Start;
    logic             Signed;
    logic [0:WIDTH-1] A;
    logic [0:WIDTH-1] B;
    logic [0:WIDTH-1] R;
    logic             Ready;

    modport master (
        output Start, Signed, A, B,
        input  R, Ready
    );

    modport slave (
        input  Start, Signed, A, B,
        output R, Ready
    );
endinterface

// File: rtl/multiplier.sv
// Radix-2 shift-add multiplier: WIDTH cycles from Start to Ready, low WIDTH bits of A*B.
module multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    multiplier_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Descending internal vectors: index 0 is the LSB here.
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] sum;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] mcand_reg,  mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [WIDTH-1:0] acc_reg,    acc_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic             neg_reg,    neg_next;
    logic [WIDTH-1:0] r_reg,      r_next;
    logic             ready_reg,  ready_next;

    assign a_in = bus.A;
    assign b_in = bus.B;

    assign a_mag = (bus.Signed && a_in[WIDTH-1]) ? -a_in : a_in;
    assign b_mag = (bus.Signed && b_in[WIDTH-1]) ? -b_in : b_in;

    assign sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            r_reg      <= '0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            neg_reg    <= neg_next;
            r_reg      <= r_next;
            ready_reg  <= ready_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        neg_next    = neg_reg;
        r_next      = r_reg;
        ready_next  = ready_reg;

        // Start wins in every state, so a pulse during BUSY restarts cleanly.
        if (bus.Start) begin
            mcand_next  = a_mag;
            mplier_next = b_mag;
            neg_next    = bus.Signed && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            acc_next    = '0;
            cnt_next    = CW'(WIDTH);
            ready_next  = 1'b0;
            state_next  = BUSY;
        end else begin
            case (state_reg)
                BUSY: begin
                    acc_next    = sum;
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    cnt_next    = cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        r_next     = neg_reg ? -sum : sum;
                        ready_next = 1'b1;
                        state_next = DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.R     = r_reg;
    assign bus.Ready = ready_reg;

endmodule

// File: tb/tb_multiplier.sv
// Randomized and directed checks of the multiplier against a plain-arithmetic product model.
module tb_multiplier;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_r;

    multiplier_if #(.WIDTH(W)) bus ();

    multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({32'b0, a}) * longint'({32'b0, b});
        return p[W-1:0];
    endfunction

    // Issue a one-edge Start pulse; afterwards the clock sits just past that edge.
    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Signed = s;
        bus.A      = a;
        bus.B      = b;
        @(posedge clk);
        #1;
        check("ready_drop", {31'b0, bus.Ready}, '0);
        check("r_hold_on_start", bus.R, exp_r);
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    // Count edges after the start edge until Ready rises, bounded.
    task automatic wait_ready(input string tag, input logic [W-1:0] expect_r);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.Ready) break;
            check({tag, "_r_busy"}, bus.R, exp_r);
        end
        check({tag, "_latency"}, W'(n), W'(32));
        check({tag, "_r"}, bus.R, expect_r);
        exp_r = expect_r;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] e;
        e = ref_mul(a, b, s);
        pulse_start(a, b, s);
        wait_ready(tag, e);
        $display("%s: signed=%0d a=%h b=%h -> r=%h (model %h)", tag, s, a, b, bus.R, e);
    endtask

    initial begin
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        rst_n      = 1'b0;
        exp_r      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, bus.Ready}, '0);
        check("reset_r", bus.R, '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u_3x5",   32'd3, 32'd5, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("done_hold_ready", {31'b0, bus.Ready}, 32'd1);
            check("done_hold_r", bus.R, 32'h0000000F);
        end
        run_op("u_7x9",   32'd7, 32'd9, 1'b0);
        run_op("s_m4x8",  -32'sd4, 32'd8, 1'b1);
        check("s_m4x8_const", bus.R, 32'hFFFFFFE0);
        run_op("s_5xm2",  32'd5, -32'sd2, 1'b1);
        check("s_5xm2_const", bus.R, 32'hFFFFFFF6);
        run_op("s_m15xm12", -32'sd15, -32'sd12, 1'b1);
        check("s_m15xm12_const", bus.R, 32'd180);
        run_op("u_trunc", 32'hFFFFFFFF, 32'd2, 1'b0);
        check("u_trunc_const", bus.R, 32'hFFFFFFFE);
        run_op("zero",    32'd0, 32'h12345678, 1'b1);
        run_op("min_neg", 32'h80000000, 32'h80000000, 1'b1);
        run_op("min_x_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1);

        // Operand change in DONE without Start must not disturb R.
        @(negedge clk);
        bus.A = 32'hDEADBEEF;
        bus.B = 32'h0BADF00D;
        repeat (4) @(posedge clk);
        #1;
        check("done_operand_change", bus.R, exp_r);

        // Restart mid-BUSY: latency measured from the second Start.
        pulse_start(32'd1000, 32'd1000, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
            check("pre_restart_busy", {31'b0, bus.Ready}, '0);
        end
        pulse_start(32'd6, 32'd7, 1'b0);
        wait_ready("restart", 32'd42);
        $display("restart: a=6 b=7 -> r=%h", bus.R);

        // Reset mid-BUSY discards the operation.
        pulse_start(32'd11, 32'd13, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_ready", {31'b0, bus.Ready}, '0);
        check("midreset_r", bus.R, '0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_r = '0;
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (bus.Ready) seen++;
            end
            check("no_ready_after_reset", W'(seen), '0);
        end
        $display("reset mid-busy: r=%h ready=%0d", bus.R, bus.Ready);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 5 == 1) ra = ra >> ($urandom_range(16, 31));
            run_op($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
